// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the multi-cycle data-memory responder.
package dmem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = WORD_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_e;

   // Width that holds LATENCY-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous byte-masked write, combinational read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory with programmable wait states and a stall/valid handshake.
// Optional byte-enable stores are built with DMEM_BYTE_WRITE_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       req_addr_i,
   input  logic              req_rd_i,
   input  logic              req_wr_i,
   input  logic [31:0]       req_wdata_i,
`ifdef DMEM_BYTE_WRITE_EN
   input  logic [3:0]        req_be_i,
`endif
   output logic              stall_o,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              err_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = cnt_width(LATENCY);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   state_e              state_q;
   logic [CW-1:0]       cnt_q;
   logic [AW-1:0]       idx_q;
   logic [WORD_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;
   logic                is_wr_q;
   logic                fault_q;
   logic                rsp_valid_q;
   logic                err_q;
   logic [WORD_W-1:0]   rdata_q;

   logic                req_any;
   logic                fault_d;
   logic [BE_W-1:0]     be_d;
   logic                access_d;
   logic                mem_we;
   logic [WORD_W-1:0]   mem_rdata;
   logic                unused_addr;

   assign req_any = req_rd_i | req_wr_i;

`ifdef DMEM_BYTE_WRITE_EN
   assign be_d        = req_be_i;
   assign fault_d     = (req_rd_i & req_wr_i) | (req_wr_i & (req_be_i == '0));
   assign unused_addr = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};
`else
   assign be_d        = '1;
   assign fault_d     = (req_rd_i & req_wr_i) | (req_addr_i[1:0] != 2'b00);
   assign unused_addr = ^req_addr_i[31:AW+2];
`endif

   // Completion edge; a flushed request (both lines low) never reaches it.
   assign access_d = (state_q == WAIT) && req_any && (cnt_q == '0);
   assign mem_we   = access_d && is_wr_q && !fault_q && !rst_i;

   assign stall_o     = ((state_q == IDLE) && req_any) || (state_q == WAIT);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign err_o       = err_q;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .be_i    (be_q),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         is_wr_q     <= 1'b0;
         fault_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               rsp_valid_q <= 1'b0;
               err_q       <= 1'b0;
               if (req_any) begin
                  idx_q   <= req_addr_i[AW+1:2];
                  wdata_q <= req_wdata_i;
                  be_q    <= be_d;
                  is_wr_q <= req_wr_i;
                  fault_q <= fault_d;
                  cnt_q   <= CNT_INIT;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (!req_any) begin
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  state_q     <= DONE;
                  rsp_valid_q <= 1'b1;
                  err_q       <= fault_q;
                  if (fault_q) begin
                     rdata_q <= '0;
                  end else if (!is_wr_q) begin
                     rdata_q <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               rsp_valid_q <= 1'b0;
               err_q       <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
